pi_waveform_stream_loader: RTL and testbench

AXI-Stream master that drives the waveform-loading input of the PI waveform controller. It accepts 16-bit samples one per cycle from a local source (BRAM reader, DMA width converter or test-pattern generator) and packs them four per 64-bit beat. It frames a load of a programmed sample count, marking the final beat with tlast, and reports progress and completion to the control logic in the AXI-Lite clock domain.

---
 rtl/pi_waveform_pkg.sv | 20 ++
 rtl/waveform_beat_packer.sv | 71 +++++++
 rtl/pi_waveform_stream_loader.sv | 149 ++++++++++++++
 tb/tb_pi_waveform_stream_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_waveform_pkg.sv
// Shared types and constants for the PI waveform stream loader.
// The packing ratio and beat-count helper live here so the loader and its consumers agree.
package pi_waveform_pkg;

    localparam int unsigned BEAT_WIDTH       = 64;
    localparam int unsigned SAMPLES_PER_BEAT = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        ABORT,
        DONE
    } loader_state_t;

    function automatic int unsigned beats_for(input int unsigned n);
        return (n + SAMPLES_PER_BEAT - 1) / SAMPLES_PER_BEAT;
    endfunction

endpackage

// File: rtl/waveform_beat_packer.sv
// Packs samples LSB-first into beats and zero-fills a short final beat.
// A beat completing this cycle is offered combinationally so it can bypass the pack register.
module waveform_beat_packer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BEAT_WIDTH   = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_fire,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic                    i_last,
    input  logic                    i_take,
    output logic                    o_full,
    output logic                    o_beat_avail,
    output logic [BEAT_WIDTH-1:0]   o_beat_data,
    output logic                    o_beat_last
);

    localparam int LANES  = BEAT_WIDTH / SAMPLE_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0]     r_lane;
    logic [BEAT_WIDTH-1:0] r_pack;
    logic                  r_full;
    logic                  r_last;
    logic [BEAT_WIDTH-1:0] w_merged;
    logic                  w_complete;

    // NOTE: always_comb assigns a full default before any partial update, so no latch is inferred.
    always_comb begin
        w_merged = (r_lane == '0) ? '0 : r_pack;
        for (int k = 0; k < LANES; k++) begin
            if (r_lane == LANE_W'(k)) begin
                w_merged[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = i_sample;
            end
        end
    end

    assign w_complete   = i_fire && ((r_lane == LANE_W'(LANES - 1)) || i_last);
    assign o_full       = r_full;
    assign o_beat_avail = r_full || w_complete;
    assign o_beat_data  = r_full ? r_pack : w_merged;
    assign o_beat_last  = r_full ? r_last : i_last;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane <= '0;
            r_pack <= '0;
            r_full <= 1'b0;
            r_last <= 1'b0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_pack <= '0;
            r_full <= 1'b0;
            r_last <= 1'b0;
        end else begin
            if (i_fire) begin
                r_pack <= w_merged;
                r_lane <= w_complete ? '0 : r_lane + LANE_W'(1);
            end
            if (w_complete) begin
                r_last <= i_last;
            end
            // A stored beat leaving while a new one completes keeps the register occupied.
            r_full <= r_full ? (!i_take || w_complete) : (w_complete && !i_take);
        end
    end

endmodule

// File: rtl/pi_waveform_stream_loader.sv
// AXI-Stream master that frames a load of N 16-bit samples into 64-bit beats with tlast.
// The FSM and output register live here; lane packing is in waveform_beat_packer.
module pi_waveform_stream_loader #(
    parameter int BUFFER_DEPTH = 16384,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BEAT_WIDTH   = 64,
    parameter int LEN_WIDTH    = $clog2(BUFFER_DEPTH) + 1
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    num_samples,
    input  logic                    abort,
    input  logic [SAMPLE_WIDTH-1:0] s_axis_sample_tdata,
    input  logic                    s_axis_sample_tvalid,
    output logic                    s_axis_sample_tready,
    output logic [BEAT_WIDTH-1:0]   m_axis_waveform_tdata,
    output logic                    m_axis_waveform_tvalid,
    input  logic                    m_axis_waveform_tready,
    output logic                    m_axis_waveform_tlast,
    output logic                    busy,
    output logic                    done,
    output logic                    len_error,
    output logic [LEN_WIDTH-1:0]    samples_sent
);

    import pi_waveform_pkg::*;

    loader_state_t         r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_count;
    logic                  r_len_error;
    logic [BEAT_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;

    logic                  w_active;
    logic                  w_out_free;
    logic                  w_sample_fire;
    logic                  w_beat_fire;
    logic                  w_is_last;
    logic                  w_len_ok;
    logic                  w_clear;
    logic                  w_load;
    logic                  w_pack_full;
    logic                  w_beat_avail;
    logic [BEAT_WIDTH-1:0] w_beat_data;
    logic                  w_beat_last;

    assign w_active      = (r_state == RUN) || (r_state == FLUSH);
    assign w_out_free    = !r_out_valid || m_axis_waveform_tready;
    assign w_sample_fire = s_axis_sample_tvalid && s_axis_sample_tready;
    assign w_beat_fire   = r_out_valid && m_axis_waveform_tready;
    assign w_is_last     = (r_count + LEN_WIDTH'(1)) == r_len;
    assign w_len_ok      = (num_samples != '0) && (num_samples <= LEN_WIDTH'(BUFFER_DEPTH));
    // Accepted start and accepted abort both throw away any partial pack.
    assign w_clear       = ((r_state == IDLE) && start && w_len_ok) || (w_active && abort);
    assign w_load        = w_active && !abort && w_beat_avail && w_out_free;

    assign s_axis_sample_tready   = (r_state == RUN) && !(w_pack_full && !w_out_free);
    assign m_axis_waveform_tdata  = r_out_data;
    assign m_axis_waveform_tvalid = r_out_valid;
    assign m_axis_waveform_tlast  = r_out_last;
    assign busy                   = (r_state == RUN) || (r_state == FLUSH) || (r_state == ABORT);
    assign done                   = (r_state == DONE);
    assign len_error              = r_len_error;
    assign samples_sent           = r_count;

    waveform_beat_packer #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .BEAT_WIDTH   (BEAT_WIDTH)
    ) u_packer (
        .i_clk        (s_axi_aclk),
        .i_rst_n      (s_axi_aresetn),
        .i_clear      (w_clear),
        .i_fire       (w_sample_fire),
        .i_sample     (s_axis_sample_tdata),
        .i_last       (w_is_last),
        .i_take       (w_load),
        .o_full       (w_pack_full),
        .o_beat_avail (w_beat_avail),
        .o_beat_data  (w_beat_data),
        .o_beat_last  (w_beat_last)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_len_error <= 1'b0;
        end else begin
            r_len_error <= 1'b0;
            if (w_sample_fire && (r_count != r_len)) begin
                r_count <= r_count + LEN_WIDTH'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_len   <= num_samples;
                            r_count <= '0;
                            r_state <= RUN;
                        end else begin
                            r_len_error <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= ABORT;
                    end else if (w_sample_fire && w_is_last) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        r_state <= ABORT;
                    end else if (w_beat_fire && r_out_last) begin
                        r_state <= DONE;
                    end
                end
                ABORT: begin
                    if (w_out_free) begin
                        r_state <= IDLE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Once valid, data and last are frozen until the consumer takes the beat.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_beat_data;
            r_out_last  <= w_beat_last;
        end else if (m_axis_waveform_tready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pi_waveform_stream_loader.sv
// Directed bench for pi_waveform_stream_loader: a packing model pushes expected beats
// as samples are accepted, and each delivered beat is popped and compared.
module tb_pi_waveform_stream_loader;

    import pi_waveform_pkg::*;

    localparam int LEN_W = 15;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic             s_axi_aclk = 1'b0;
    logic             s_axi_aresetn;
    logic             start;
    logic [LEN_W-1:0] num_samples;
    logic             abort;
    logic [15:0]      s_axis_sample_tdata;
    logic             s_axis_sample_tvalid;
    logic             s_axis_sample_tready;
    logic [63:0]      m_axis_waveform_tdata;
    logic             m_axis_waveform_tvalid;
    logic             m_axis_waveform_tready;
    logic             m_axis_waveform_tlast;
    logic             busy;
    logic             done;
    logic             len_error;
    logic [LEN_W-1:0] samples_sent;

    always #5 s_axi_aclk = ~s_axi_aclk;

    pi_waveform_stream_loader dut (
        .s_axi_aclk             (s_axi_aclk),
        .s_axi_aresetn          (s_axi_aresetn),
        .start                  (start),
        .num_samples            (num_samples),
        .abort                  (abort),
        .s_axis_sample_tdata    (s_axis_sample_tdata),
        .s_axis_sample_tvalid   (s_axis_sample_tvalid),
        .s_axis_sample_tready   (s_axis_sample_tready),
        .m_axis_waveform_tdata  (m_axis_waveform_tdata),
        .m_axis_waveform_tvalid (m_axis_waveform_tvalid),
        .m_axis_waveform_tready (m_axis_waveform_tready),
        .m_axis_waveform_tlast  (m_axis_waveform_tlast),
        .busy                   (busy),
        .done                   (done),
        .len_error              (len_error),
        .samples_sent           (samples_sent)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] src_q[$];
    beat_t       exp_q[$];
    bit          tready_ctl, pulse_start, pulse_abort;
    int          tick_no, done_seen, lenerr_seen, beats_seen;
    bit          busy_seen, obs_busy, obs_s_tready;
    int          done_tick, last_beat_tick, first_valid_tick, first_push_tick;
    int          first_fire_tick, last_fire_tick;
    logic [63:0] last_beat_data;
    bit          prev_block;
    logic [63:0] prev_data;
    logic        prev_last;
    int          mdl_n, mdl_cnt, mdl_lane;
    logic [63:0] mdl_pack;
    bit          mdl_active;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_trk();
        done_seen = 0; lenerr_seen = 0; beats_seen = 0; busy_seen = 0;
        done_tick = -1; last_beat_tick = -1; first_valid_tick = -1; first_push_tick = -1;
        first_fire_tick = -1; last_fire_tick = -1; last_beat_data = '0;
    endtask

    task automatic mdl_discard();
        mdl_pack = '0; mdl_lane = 0; mdl_active = 0;
    endtask

    task automatic mdl_accept(input logic [15:0] d, input bit ab);
        mdl_pack[mdl_lane*16 +: 16] = d;
        mdl_lane++;
        mdl_cnt++;
        if (ab) begin
            mdl_discard();
        end else if (mdl_lane == SAMPLES_PER_BEAT || mdl_cnt == mdl_n) begin
            exp_q.push_back('{data: mdl_pack, last: (mdl_cnt == mdl_n)});
            if (first_push_tick < 0) first_push_tick = tick_no;
            if (mdl_cnt == mdl_n) mdl_active = 0;
            mdl_pack = '0;
            mdl_lane = 0;
        end
    endtask

    // One clock: drive at the falling edge, observe registered outputs, predict handshakes.
    task automatic tick();
        beat_t b;
        bit    abort_now;
        @(negedge s_axi_aclk);
        start       = pulse_start;
        abort       = pulse_abort;
        abort_now   = pulse_abort;
        pulse_start = 0;
        pulse_abort = 0;
        s_axis_sample_tvalid   = (src_q.size() != 0);
        s_axis_sample_tdata    = (src_q.size() != 0) ? src_q[0] : 16'h0;
        m_axis_waveform_tready = tready_ctl;
        tick_no++;
        if (done) begin done_seen++; done_tick = tick_no; end
        if (len_error) lenerr_seen++;
        if (busy) busy_seen = 1;
        obs_busy = busy;
        if (m_axis_waveform_tvalid && first_valid_tick < 0) first_valid_tick = tick_no;
        if (prev_block) begin
            check("hold_tvalid", 64'(m_axis_waveform_tvalid), 64'd1);
            check("hold_tdata", m_axis_waveform_tdata, prev_data);
            check("hold_tlast", 64'(m_axis_waveform_tlast), 64'(prev_last));
        end
        #1;
        obs_s_tready = s_axis_sample_tready;
        prev_block   = m_axis_waveform_tvalid && !m_axis_waveform_tready;
        prev_data    = m_axis_waveform_tdata;
        prev_last    = m_axis_waveform_tlast;
        if (m_axis_waveform_tvalid && m_axis_waveform_tready) begin
            beats_seen++;
            last_beat_data = m_axis_waveform_tdata;
            if (m_axis_waveform_tlast) last_beat_tick = tick_no;
            if (exp_q.size() == 0) begin
                check("beat_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                b = exp_q.pop_front();
                check("beat_tdata", m_axis_waveform_tdata, b.data);
                check("beat_tlast", 64'(m_axis_waveform_tlast), 64'(b.last));
            end
        end
        if (s_axis_sample_tvalid && s_axis_sample_tready) begin
            if (first_fire_tick < 0) first_fire_tick = tick_no;
            last_fire_tick = tick_no;
            check("sample_in_load", 64'(mdl_active && (mdl_cnt < mdl_n)), 64'd1);
            mdl_accept(src_q.pop_front(), abort_now);
        end else if (abort_now) begin
            mdl_discard();
        end
    endtask

    task automatic begin_load(input int n, input logic [15:0] first, input int cnt);
        for (int i = 0; i < cnt; i++) src_q.push_back(first + 16'(i));
        num_samples = LEN_W'(n);
        pulse_start = 1;
        mdl_n = n; mdl_cnt = 0; mdl_lane = 0; mdl_pack = '0; mdl_active = 1;
        clr_trk();
    endtask

    task automatic run_until_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = !obs_busy && (exp_q.size() == 0) && (src_q.size() == 0) && !prev_block;
        end
        check("idle_reached", 64'(ok), 64'd1);
    endtask

    task automatic check_outputs_zero();
        check("rst_tvalid", 64'(m_axis_waveform_tvalid), 64'd0);
        check("rst_tdata", m_axis_waveform_tdata, 64'd0);
        check("rst_tlast", 64'(m_axis_waveform_tlast), 64'd0);
        check("rst_s_tready", 64'(s_axis_sample_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_len_error", 64'(len_error), 64'd0);
        check("rst_samples_sent", 64'(samples_sent), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_axi_aresetn = 0; start = 0; abort = 0; num_samples = '0;
        s_axis_sample_tdata = '0; s_axis_sample_tvalid = 0; m_axis_waveform_tready = 0;
        tready_ctl = 0; pulse_start = 0; pulse_abort = 0; tick_no = 0; prev_block = 0;
        obs_busy = 0; obs_s_tready = 0; mdl_active = 0; mdl_n = 0; mdl_cnt = 0;
        mdl_lane = 0; mdl_pack = '0;
        clr_trk();
        repeat (3) @(negedge s_axi_aclk);
        check_outputs_zero();
        s_axi_aresetn = 1;

        // 1: N=8 streaming, mid-load start ignored, latency/throughput/done timing
        tready_ctl = 1;
        begin_load(8, 16'h0001, 8);
        tick(); tick(); tick();
        num_samples = LEN_W'(3);
        pulse_start = 1;
        tick();
        run_until_idle(50);
        check("t1_beats", 64'(beats_seen), 64'(beats_for(8)));
        check("t1_last_beat", last_beat_data, 64'h0008_0007_0006_0005);
        check("t1_done_timing", 64'(done_tick), 64'(last_beat_tick + 1));
        check("t1_latency", 64'(first_valid_tick), 64'(first_push_tick + 1));
        check("t1_no_bubbles", 64'(last_fire_tick - first_fire_tick), 64'd7);
        tick();
        check("t1_done_once", 64'(done_seen), 64'd1);
        check("t1_samples_sent", 64'(samples_sent), 64'd8);

        // 2: N=6, zero-filled final beat
        begin_load(6, 16'h0001, 6);
        tick();
        run_until_idle(50);
        check("t2_beats", 64'(beats_seen), 64'(beats_for(6)));
        check("t2_last_beat", last_beat_data, 64'h0000_0000_0006_0005);
        check("t2_done", 64'(done_seen), 64'd1);

        // 3: N=8 with consumer stalled for 10 cycles after beat0 becomes valid
        tready_ctl = 0;
        begin_load(8, 16'h0011, 8);
        tick();
        for (int i = 0; i < 20 && !m_axis_waveform_tvalid; i++) tick();
        check("t3_beat0_valid", 64'(m_axis_waveform_tvalid), 64'd1);
        repeat (10) tick();
        check("t3_s_tready_low", 64'(obs_s_tready), 64'd0);
        check("t3_samples_sent", 64'(samples_sent), 64'd8);
        check("t3_src_drained", 64'(src_q.size()), 64'd0);
        tready_ctl = 1;
        run_until_idle(30);
        check("t3_beats", 64'(beats_seen), 64'd2);
        check("t3_done", 64'(done_seen), 64'd1);

        // 4: out-of-range lengths rejected
        clr_trk();
        num_samples = LEN_W'(0);
        pulse_start = 1;
        tick(); tick();
        num_samples = LEN_W'(16385);
        pulse_start = 1;
        tick(); tick(); tick();
        check("t4_len_error", 64'(lenerr_seen), 64'd2);
        check("t4_busy", 64'(busy_seen), 64'd0);
        check("t4_beats", 64'(beats_seen), 64'd0);

        // 5: abort with beat0 pending and one sample in the pack
        tready_ctl = 0;
        begin_load(16, 16'h0101, 5);
        tick();
        for (int i = 0; i < 20 && src_q.size() != 0; i++) tick();
        tick();
        pulse_abort = 1;
        tick();
        tready_ctl = 1;
        tick();
        check("t5_s_tready_after_abort", 64'(obs_s_tready), 64'd0);
        run_until_idle(20);
        check("t5_beats", 64'(beats_seen), 64'd1);
        check("t5_no_done", 64'(done_seen), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_samples_sent", 64'(samples_sent), 64'd5);

        // 6: asynchronous reset mid-load, then a clean N=4 load
        tready_ctl = 1;
        begin_load(8, 16'h0201, 3);
        tick();
        for (int i = 0; i < 20 && src_q.size() != 0; i++) tick();
        tick();
        check("t6_samples_before_rst", 64'(samples_sent), 64'd3);
        s_axi_aresetn = 0;
        #1;
        check_outputs_zero();
        exp_q.delete();
        src_q.delete();
        mdl_discard();
        prev_block = 0;
        repeat (2) @(negedge s_axi_aclk);
        s_axi_aresetn = 1;
        begin_load(4, 16'h0301, 4);
        tick();
        run_until_idle(30);
        check("t6_beats", 64'(beats_seen), 64'(beats_for(4)));
        check("t6_beat", last_beat_data, 64'h0304_0303_0302_0301);
        check("t6_done", 64'(done_seen), 64'd1);
        check("t6_done_timing", 64'(done_tick), 64'(last_beat_tick + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
